// File: rtl/spi_master_rx_fifo.sv
// SPI receive path: serial-to-parallel assembly over 1/2/4 lanes feeding a small word FIFO.
// Optional macro SPI_RX_LSB_FIRST_EN selects LSB-first (right-shift) word assembly.
module spi_master_rx_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          en,
    input  logic                          rx_edge,
    input  logic [3:0]                    sdi,
    input  logic [1:0]                    mode,
    input  logic [CNT_WIDTH-1:0]          counter_in,
    input  logic                          counter_in_upd,
    output logic [DATA_WIDTH-1:0]         data,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic                          rx_done,
    output logic                          clk_en_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LW  = PW + 1;
    localparam int WCW = $clog2(DATA_WIDTH + 1);
    localparam int BW  = CNT_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RECV, HOLD} state_t;

    state_t                r_state, w_state_nxt;
    logic [1:0]            r_mode;
    logic [CNT_WIDTH-1:0]  r_bit_cnt, r_target;
    logic [WCW-1:0]        r_word_cnt, w_word_cnt_nxt, w_lanes;
    logic [BW-1:0]         w_bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt, w_grp, w_push_data;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wptr, r_rptr;
    logic [LW-1:0]         r_level, w_level_nxt;
    logic                  w_full, w_sample, w_done, w_word_full, w_push, w_pop, w_hold;

    // Lane count and the incoming bit group, ordered so the earliest bit lands first in the word.
    always_comb begin
        w_grp   = '0;
        w_lanes = WCW'(1);
        case (r_mode)
            2'b01: begin
                w_lanes = WCW'(2);
`ifdef SPI_RX_LSB_FIRST_EN
                w_grp[1:0] = {sdi[0], sdi[1]};
`else
                w_grp[1:0] = sdi[1:0];
`endif
            end
            2'b10: begin
                w_lanes = WCW'(4);
`ifdef SPI_RX_LSB_FIRST_EN
                w_grp[3:0] = {sdi[0], sdi[1], sdi[2], sdi[3]};
`else
                w_grp[3:0] = sdi[3:0];
`endif
            end
            default: begin
                w_lanes  = WCW'(1);
                w_grp[0] = sdi[0];
            end
        endcase
    end

`ifdef SPI_RX_LSB_FIRST_EN
    logic [WCW-1:0] w_rshamt;
    assign w_shift_nxt = (r_shift >> w_lanes) | (w_grp << (WCW'(DATA_WIDTH) - w_lanes));
    assign w_rshamt    = WCW'(DATA_WIDTH) - w_word_cnt_nxt;
    // Partial word sits at the top of the register; move it down to bit 0.
    assign w_push_data = w_shift_nxt >> w_rshamt;
`else
    assign w_shift_nxt = (r_shift << w_lanes) | w_grp;
    assign w_push_data = w_shift_nxt;
`endif

    assign w_full         = (r_level == LW'(FIFO_DEPTH));
    assign w_sample       = (r_state == RECV) && rx_edge && !w_full;
    assign w_word_cnt_nxt = r_word_cnt + w_lanes;
    assign w_bit_cnt_nxt  = {1'b0, r_bit_cnt} + BW'(w_lanes);
    assign w_done         = w_sample && (w_bit_cnt_nxt >= {1'b0, r_target});
    assign w_word_full    = (w_word_cnt_nxt == WCW'(DATA_WIDTH));
    assign w_push         = w_sample && (w_word_full || w_done);
    assign w_pop          = data_valid && data_ready;
    assign w_hold         = w_push && !w_done && (w_level_nxt == LW'(FIFO_DEPTH));

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LW'(1);
            2'b01:   w_level_nxt = r_level - LW'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (en) w_state_nxt = RECV;
            RECV: begin
                if (w_done) begin
                    w_state_nxt = IDLE;
                end else if (w_hold || w_full) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD:    if (!w_full) w_state_nxt = RECV;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_mode     <= 2'b00;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_shift    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && en) begin
                r_mode     <= mode;
                r_bit_cnt  <= '0;
                r_word_cnt <= '0;
                r_shift    <= '0;
            end else if (w_sample) begin
                r_bit_cnt <= w_bit_cnt_nxt[CNT_WIDTH-1:0];
                if (w_push) begin
                    r_word_cnt <= '0;
                    r_shift    <= '0;
                end else begin
                    r_word_cnt <= w_word_cnt_nxt;
                    r_shift    <= w_shift_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_target <= CNT_WIDTH'(8);
        end else if (counter_in_upd) begin
            r_target <= counter_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            r_level <= w_level_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_push_data;
    end

    assign data       = r_mem[r_rptr];
    assign data_valid = (r_level != '0);
    assign fifo_level = r_level;
    assign rx_done    = w_done;
    // Drop the clock request in the very cycle a push fills the FIFO.
    assign clk_en_o   = (r_state == RECV) && !w_hold && !w_full;

endmodule
